// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and entry widths for the fetch sequencer
package fetch_pkg;

    localparam logic [3:0]  EXC_INSN_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INSN_ACCESS     = 4'd1;
    localparam logic [31:0] NOP_INSN            = 32'h0000_0013;
    localparam int          INSTR_W             = 32;
    localparam int          EXC_CODE_W          = 4;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // Entry layout: {pc, instr, exc_en, exc_code, exc_val}
    function automatic int entry_width(input int xlen);
        return 2 * xlen + INSTR_W + EXC_CODE_W + 1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect, instruction memory and decode-side signals of the fetch sequencer
interface fetch_ctrl_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] mem_addr;
    logic [31:0]     mem_instr;
    logic            mem_exc_en;
    logic [3:0]      mem_exc_code;
    logic [XLEN-1:0] mem_exc_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_exc_en;
    logic [3:0]      out_exc_code;
    logic [XLEN-1:0] out_exc_val;

    modport master (
        input  redirect_valid, redirect_pc, mem_instr, mem_exc_en, mem_exc_code, mem_exc_val,
        input  out_ready,
        output mem_addr, out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_instr, mem_exc_en, mem_exc_code, mem_exc_val,
        output out_ready,
        input  mem_addr, out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush; head reads the last popped entry while empty
module fetch_fifo #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_DATA = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= IDLE_DATA;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset: it is never visible while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC, run/halt sequencing and entry formation toward decode
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);
    localparam int EW = entry_width(XLEN);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [EW-1:0] IDLE_ENTRY = {{XLEN{1'b0}}, NOP_INSN, 1'b0, 4'd0, {XLEN{1'b0}}};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pop, push;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   wdata, rdata;
    logic            e_exc;
    logic [3:0]      e_code;
    logic [XLEN-1:0] e_val;
    logic [31:0]     e_instr;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = (state_q == FETCH_RUN) & (!fifo_full | pop) & !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Misalignment outranks a memory fault; either one parks the PC and halts
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        e_exc   = 1'b0;
        e_code  = 4'd0;
        e_val   = '0;
        e_instr = bus.mem_instr;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            state_d = FETCH_RUN;
        end else if (push) begin
            if (pc_q[1:0] != 2'b00) begin
                e_exc   = 1'b1;
                e_code  = EXC_INSN_MISALIGNED;
                e_val   = pc_q;
                e_instr = NOP_INSN;
                state_d = FETCH_HALT;
            end else if (bus.mem_exc_en) begin
                e_exc   = 1'b1;
                e_code  = bus.mem_exc_code;
                e_val   = bus.mem_exc_val;
                e_instr = NOP_INSN;
                state_d = FETCH_HALT;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    assign wdata = {pc_q, e_instr, e_exc, e_code, e_val};

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (EW),
        .IDLE_DATA (IDLE_ENTRY)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop & !bus.redirect_valid),
        .flush_i (bus.redirect_valid),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.mem_addr  = pc_q;
    assign bus.out_valid = !fifo_empty;
    assign {bus.out_pc, bus.out_instr, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val} = rdata;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with an instruction memory model
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int              XLEN     = 64;
    localparam int              DEPTH    = 2;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            exc_en;
        logic [3:0]      code;
        logic [XLEN-1:0] val;
    } entry_t;

    logic   clk      = 1'b0;
    logic   rst_n    = 1'b0;
    logic   fault_en = 1'b0;
    int     vectors     = 0;
    int     miscompares = 0;
    entry_t exp_q[$];
    entry_t mon_got, mon_exp;

    fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    fetch_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [XLEN-1:0] a);
        return {a[26:0], 5'b0} + 32'h13;
    endfunction

    always_comb begin
        bus.mem_instr    = imem_word(bus.mem_addr);
        bus.mem_exc_en   = fault_en && (bus.mem_addr == 64'h2000);
        bus.mem_exc_code = EXC_INSN_ACCESS;
        bus.mem_exc_val  = bus.mem_addr;
    end

    // Inputs only change just after a rising edge, so a handshake seen here happens at the next edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            mon_got = {bus.out_pc, bus.out_instr, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h exc=%b, required no entry",
                         mon_got.pc, mon_got.instr, mon_got.exc_en);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL sb_entry: got pc=%h instr=%h exc=%b code=%0d val=%h, required pc=%h instr=%h exc=%b code=%0d val=%h",
                             mon_got.pc, mon_got.instr, mon_got.exc_en, mon_got.code, mon_got.val,
                             mon_exp.pc, mon_exp.instr, mon_exp.exc_en, mon_exp.code, mon_exp.val);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_seq(input logic [XLEN-1:0] base, input int n);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc     = base + XLEN'(4 * i);
            e.instr  = imem_word(e.pc);
            e.exc_en = 1'b0;
            e.code   = 4'd0;
            e.val    = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic sb_fault(input logic [XLEN-1:0] pc, input logic [3:0] code);
        entry_t e;
        e.pc     = pc;
        e.instr  = NOP_INSN;
        e.exc_en = 1'b1;
        e.code   = code;
        e.val    = pc;
        exp_q.push_back(e);
    endtask

    task automatic redirect(input logic [XLEN-1:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        exp_q.delete();
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        vectors += 7;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_pc !== '0) begin miscompares++; $display("FAIL reset_pc: got %h, required 0", bus.out_pc); end
        if (bus.out_instr !== NOP_INSN) begin miscompares++; $display("FAIL reset_instr: got %h, required %h", bus.out_instr, NOP_INSN); end
        if (bus.out_exc_en !== 1'b0) begin miscompares++; $display("FAIL reset_exc_en: got %b, required 0", bus.out_exc_en); end
        if (bus.out_exc_code !== 4'd0) begin miscompares++; $display("FAIL reset_exc_code: got %0d, required 0", bus.out_exc_code); end
        if (bus.out_exc_val !== '0) begin miscompares++; $display("FAIL reset_exc_val: got %h, required 0", bus.out_exc_val); end
        if (bus.mem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_mem_addr: got %h, required %h", bus.mem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        exp_q.delete();
        sb_seq(RESET_PC, 64);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors += 2;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC + XLEN'(4 * i)) begin
                miscompares++;
                $display("FAIL stream_head: got valid=%b pc=%h, required valid=1 pc=%h", bus.out_valid, bus.out_pc, RESET_PC + XLEN'(4 * i));
            end
            if (bus.out_exc_en !== 1'b0) begin miscompares++; $display("FAIL stream_exc: got %b, required 0", bus.out_exc_en); end
        end
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] head;
        head = bus.out_pc;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== head) begin
                miscompares++;
                $display("FAIL stall_head: got valid=%b pc=%h, required valid=1 pc=%h", bus.out_valid, bus.out_pc, head);
            end
        end
        vectors++;
        if (bus.mem_addr !== head + XLEN'(4 * DEPTH)) begin
            miscompares++;
            $display("FAIL stall_mem_addr: got %h, required %h", bus.mem_addr, head + XLEN'(4 * DEPTH));
        end
        bus.out_ready = 1'b1;
        step(5);
    endtask

    task automatic test_redirect_full();
        bus.out_ready = 1'b0;
        step(2);
        bus.out_ready = 1'b1;
        redirect(64'h40);
        sb_seq(64'h40, 32);
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_valid: got %b, required 0", bus.out_valid); end
        if (bus.mem_addr !== 64'h40) begin miscompares++; $display("FAIL redir_mem_addr: got %h, required 40", bus.mem_addr); end
        step(1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h40) begin
            miscompares++;
            $display("FAIL redir_first: got valid=%b pc=%h, required valid=1 pc=40", bus.out_valid, bus.out_pc);
        end
        step(3);
    endtask

    task automatic test_wrap();
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        sb_seq(64'hFFFF_FFFF_FFFF_FFF8, 16);
        step(3);
        vectors += 2;
        if (bus.out_pc !== 64'h0) begin miscompares++; $display("FAIL wrap_pc: got %h, required 0", bus.out_pc); end
        if (bus.mem_addr !== 64'h4) begin miscompares++; $display("FAIL wrap_mem_addr: got %h, required 4", bus.mem_addr); end
        step(2);
    endtask

    task automatic test_fetch_fault();
        fault_en = 1'b1;
        redirect(64'h2000);
        sb_fault(64'h2000, EXC_INSN_ACCESS);
        step(1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_exc_en !== 1'b1 || bus.out_instr !== NOP_INSN) begin
            miscompares++;
            $display("FAIL fault_head: got valid=%b exc=%b instr=%h, required valid=1 exc=1 instr=%h",
                     bus.out_valid, bus.out_exc_en, bus.out_instr, NOP_INSN);
        end
        step(6);
        vectors += 4;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fault_halt_valid: got %b, required 0", bus.out_valid); end
        if (bus.mem_addr !== 64'h2000) begin miscompares++; $display("FAIL fault_halt_pc: got %h, required 2000", bus.mem_addr); end
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL fault_pending: got %0d unconsumed, required 0", exp_q.size()); end
        if (bus.out_pc !== 64'h2000 || bus.out_exc_code !== EXC_INSN_ACCESS) begin
            miscompares++;
            $display("FAIL fault_hold: got pc=%h code=%0d, required pc=2000 code=1", bus.out_pc, bus.out_exc_code);
        end
    endtask

    task automatic test_misaligned();
        redirect(64'h42);
        sb_fault(64'h42, EXC_INSN_MISALIGNED);
        step(6);
        vectors += 3;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL misal_halt_valid: got %b, required 0", bus.out_valid); end
        if (bus.mem_addr !== 64'h42) begin miscompares++; $display("FAIL misal_halt_pc: got %h, required 42", bus.mem_addr); end
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL misal_pending: got %0d unconsumed, required 0", exp_q.size()); end
        fault_en = 1'b0;
        redirect(64'h0);
        sb_seq(64'h0, 32);
        step(1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin
            miscompares++;
            $display("FAIL resume_head: got valid=%b pc=%h, required valid=1 pc=0", bus.out_valid, bus.out_pc);
        end
        step(4);
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b, required 0", bus.out_valid); end
        if (bus.mem_addr !== RESET_PC) begin miscompares++; $display("FAIL async_mem_addr: got %h, required %h", bus.mem_addr, RESET_PC); end
        sb_seq(RESET_PC, 32);
        step(2);
        rst_n = 1'b1;
        step(1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL async_restart: got valid=%b pc=%h, required valid=1 pc=%h", bus.out_valid, bus.out_pc, RESET_PC);
        end
        step(4);
        bus.out_ready = 1'b0;
        step(2);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_fetch_fault();
        test_misaligned();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
